// File: rtl/i2c_pkg.sv
// Shared types for the I2C slave receive path.
// Optional feature macro: I2C_ADDR_MATCH_EN (address-match front end).
package i2c_pkg;

    localparam int unsigned I2C_BYTE_W         = 8;
    localparam int unsigned I2C_BITS_PER_FRAME = 9;
    localparam int unsigned I2C_BIT_CNT_W      = $clog2(I2C_BITS_PER_FRAME);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RX_BIT    = 3'd1,
        ACK       = 3'd2,
        NACK      = 3'd3,
        WAIT_STOP = 3'd4
    } rx_state_t;

    typedef struct packed {
        logic start;
        logic stop;
        logic scl_rise;
        logic scl_fall;
    } bus_cond_t;

endpackage

// File: rtl/i2c_bus_cond_detect.sv
// START/STOP and SCL edge detection on pre-synchronised SCL/SDA.
// Optional feature macro: I2C_ADDR_MATCH_EN (not used in this file).
module i2c_bus_cond_detect
    import i2c_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      scl_i,
    input  logic      sda_i,
    output bus_cond_t cond_c_o
);

    logic scl_d_q;
    logic sda_d_q;

    // One-cycle delayed bus copies; reset to the idle-high bus so release makes no edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            scl_d_q <= 1'b1;
            sda_d_q <= 1'b1;
        end else begin
            scl_d_q <= scl_i;
            sda_d_q <= sda_i;
        end
    end

    // Bus conditions decoded from current and delayed samples.
    always_comb begin
        cond_c_o.start    = scl_i & sda_d_q & ~sda_i;
        cond_c_o.stop     = scl_i & ~sda_d_q & sda_i;
        cond_c_o.scl_rise = ~scl_d_q & scl_i;
        cond_c_o.scl_fall = scl_d_q & ~scl_i;
    end

endmodule

// File: rtl/i2c_slave_rx_engine.sv
// I2C slave receive engine: byte deserialiser, register file and ACK/NACK driver.
// Optional feature macro: I2C_ADDR_MATCH_EN (first byte of each frame is a 7-bit address).
module i2c_slave_rx_engine
    import i2c_pkg::*;
#(
    parameter int unsigned NUM_BYTES  = 6,
    parameter logic [6:0]  SLAVE_ADDR = 7'h42
) (
    input  logic                                  FPGA_clk,
    input  logic                                  rst,
    input  logic                                  SCL,
    input  logic                                  SDA,
    input  logic                                  enable,
    output logic                                  sda_oe,
    output logic [NUM_BYTES-1:0][I2C_BYTE_W-1:0]  rx_data,
    output logic [$clog2(NUM_BYTES+1)-1:0]        byte_count,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  overflow
);

    localparam int unsigned CNT_W = $clog2(NUM_BYTES + 1);
    localparam logic [I2C_BIT_CNT_W-1:0] LAST_BIT = I2C_BIT_CNT_W'(I2C_BITS_PER_FRAME - 1);

    bus_cond_t cond;

    rx_state_t                           state_q, state_d;
    logic [I2C_BIT_CNT_W-1:0]            bit_cnt_q, bit_cnt_d;
    logic [I2C_BYTE_W-1:0]               shift_q, shift_d;
    logic [NUM_BYTES-1:0][I2C_BYTE_W-1:0] rx_data_q, rx_data_d;
    logic [CNT_W-1:0]                    byte_count_q, byte_count_d;
    logic                                overflow_q, overflow_d;
    logic                                busy_q, busy_d;
    logic                                done_q, done_d;
    logic                                sda_oe_q, sda_oe_d;
`ifdef I2C_ADDR_MATCH_EN
    logic                                addr_phase_q, addr_phase_d;
    logic                                addr_nack_q, addr_nack_d;
`else
    // SLAVE_ADDR has no effect without the address front end.
    if (SLAVE_ADDR != 7'h00) begin : g_slave_addr_inert
    end
`endif

    i2c_bus_cond_detect u_cond (
        .clk_i    (FPGA_clk),
        .rst_ni   (rst),
        .scl_i    (SCL),
        .sda_i    (SDA),
        .cond_c_o (cond)
    );

    // State and datapath registers.
    always_ff @(posedge FPGA_clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            rx_data_q    <= '0;
            byte_count_q <= '0;
            overflow_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            sda_oe_q     <= 1'b0;
`ifdef I2C_ADDR_MATCH_EN
            addr_phase_q <= 1'b0;
            addr_nack_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            rx_data_q    <= rx_data_d;
            byte_count_q <= byte_count_d;
            overflow_q   <= overflow_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            sda_oe_q     <= sda_oe_d;
`ifdef I2C_ADDR_MATCH_EN
            addr_phase_q <= addr_phase_d;
            addr_nack_q  <= addr_nack_d;
`endif
        end
    end

    // Next-state logic: enable, then START/STOP, then SCL-edge actions.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        rx_data_d    = rx_data_q;
        byte_count_d = byte_count_q;
        overflow_d   = overflow_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
`ifdef I2C_ADDR_MATCH_EN
        addr_phase_d = addr_phase_q;
        addr_nack_d  = addr_nack_q;
`endif
        if (!enable) begin
            state_d = IDLE;
            busy_d  = 1'b0;
        end else if (cond.start) begin
            state_d      = RX_BIT;
            bit_cnt_d    = '0;
            byte_count_d = '0;
            overflow_d   = 1'b0;
            busy_d       = 1'b1;
`ifdef I2C_ADDR_MATCH_EN
            addr_phase_d = 1'b1;
            addr_nack_d  = 1'b0;
`endif
        end else if (cond.stop && (state_q != IDLE)) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = (state_q != WAIT_STOP);
`ifdef I2C_ADDR_MATCH_EN
            if (addr_nack_q) begin
                done_d = 1'b0;
            end
`endif
        end else begin
            case (state_q)
                RX_BIT: begin
                    if (cond.scl_rise && (bit_cnt_q != LAST_BIT)) begin
                        shift_d   = {shift_q[I2C_BYTE_W-2:0], SDA};
                        bit_cnt_d = bit_cnt_q + I2C_BIT_CNT_W'(1);
                    end else if (cond.scl_fall && (bit_cnt_q == LAST_BIT)) begin
                        bit_cnt_d = '0;
`ifdef I2C_ADDR_MATCH_EN
                        if (addr_phase_q) begin
                            addr_phase_d = 1'b0;
                            if ((shift_q[7:1] == SLAVE_ADDR) && !shift_q[0]) begin
                                state_d = ACK;
                            end else begin
                                state_d     = NACK;
                                addr_nack_d = 1'b1;
                            end
                        end else
`endif
                        begin
                            if (byte_count_q < CNT_W'(NUM_BYTES)) begin
                                state_d = ACK;
                                for (int unsigned i = 0; i < NUM_BYTES; i++) begin
                                    if (byte_count_q == CNT_W'(i)) begin
                                        rx_data_d[i] = shift_q;
                                    end
                                end
                                byte_count_d = byte_count_q + CNT_W'(1);
                            end else begin
                                state_d    = NACK;
                                overflow_d = 1'b1;
                            end
                        end
                    end
                end
                ACK: begin
                    if (cond.scl_fall) begin
                        state_d   = RX_BIT;
                        bit_cnt_d = '0;
                    end
                end
                NACK: begin
                    if (cond.scl_fall) begin
                        state_d   = RX_BIT;
                        bit_cnt_d = '0;
`ifdef I2C_ADDR_MATCH_EN
                        if (addr_nack_q) begin
                            state_d = WAIT_STOP;
                        end
`endif
                    end
                end
                default: ;
            endcase
        end
        sda_oe_d = (state_d == ACK);
    end

    assign sda_oe     = sda_oe_q;
    assign rx_data    = rx_data_q;
    assign byte_count = byte_count_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign overflow   = overflow_q;

endmodule

// File: doc/i2c_slave_rx_engine.md
# i2c_slave_rx_engine

Parametrised I2C slave receive engine: detects START/STOP on the bus, deserialises MSB-first bytes into a NUM_BYTES-deep register file, and drives ACK/NACK on the ninth SCL clock. It sits between the slave's synchronised SCL/SDA pins and the HEX display/decode logic. It generalises the fixed-size data-in path with:
- runtime byte counting
- ACK generation
- overflow NACKing
- repeated-START handling
- an optional address-match front end

## Interface
Parameters:
- NUM_BYTES, 6, depth of receive register file (1..16)
- SLAVE_ADDR, 7'h42, 7-bit address; only used when I2C_ADDR_MATCH_EN is defined

Ports:
- FPGA_clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- SCL  in  1  bus clock, already synchronised to FPGA_clk upstream
- SDA  in  1  bus data, already synchronised to FPGA_clk upstream
- enable  in  1  block active; low forces IDLE synchronously
- sda_oe  out  1  1 = pull SDA low (ACK); pad logic makes it open-drain
- rx_data  out  NUM_BYTES x 8  received bytes; index 0 = first data byte
- byte_count  out  $clog2(NUM_BYTES+1)  bytes stored in current frame
- busy  out  1  frame in progress (START seen, no STOP yet)
- done  out  1  one-cycle pulse after STOP ends a frame
- overflow  out  1  sticky; more than NUM_BYTES bytes sent this frame

## Operation
- The block keeps internal one-cycle-delayed copies of SCL and SDA (SCL_d, SDA_d).
- Bus conditions:
  - START: SCL=1, SDA_d=1, SDA=0
  - STOP: SCL=1, SDA_d=0, SDA=1
  - SCL rise: SCL_d=0, SCL=1
  - SCL fall: SCL_d=1, SCL=0
- States: IDLE, RX_BIT, ACK, NACK, WAIT_STOP.
- IDLE → RX_BIT on START. On entry: bit_cnt=0, byte_count=0, overflow=0, busy=1.
- RX_BIT:
  - Each SCL rise shifts SDA into shift_reg LSB; bit_cnt increments.
  - At bit_cnt==8, the next SCL fall goes to ACK if byte_count<NUM_BYTES, otherwise to NACK and sets overflow=1.
- ACK:
  - sda_oe=1 from the cycle after the 8th-bit SCL fall until the following SCL fall.
  - rx_data[byte_count] ← shift_reg and byte_count+1, both on the ACK-entry cycle.
  - Then → RX_BIT with bit_cnt=0.
- NACK: sda_oe stays 0 and nothing is stored. Next SCL fall → RX_BIT (further bytes also NACK).
- STOP in any non-IDLE state → IDLE, busy=0, done=1 for one cycle. A partial byte is discarded.
- Repeated START in any non-IDLE state restarts the frame:
  - byte_count=0, bit_cnt=0, overflow=0
  - no done pulse
  - rx_data retained until overwritten
- WAIT_STOP (address mismatch only): sda_oe=0, all SCL edges ignored, exits on STOP (no done pulse) or START.
- enable=0: next cycle state=IDLE, sda_oe=0, busy=0; rx_data and byte_count are held.
- START/STOP detection has priority over SCL-edge actions in the same cycle.

## Timing
- Reset values: sda_oe=0, rx_data all 0, byte_count=0, busy=0, done=0, overflow=0, state=IDLE.
- Reset is asynchronous on assertion; mid-frame it aborts immediately and releases SDA in the same instant.
- Bit sample latency: shift_reg is updated one FPGA_clk after the SCL rise is visible on the inputs.
- sda_oe asserts one FPGA_clk after the 8th-bit SCL fall and deasserts one FPGA_clk after the 9th SCL fall. This requires FPGA_clk ≥ 8× SCL.
- done asserts the cycle after the STOP condition is detected and lasts exactly one cycle.
- byte_count saturates at NUM_BYTES and never wraps.

## Configuration
I2C_ADDR_MATCH_EN:
- Defined:
  - The first byte after each START/repeated START is the address byte; it is acknowledged only if [7:1]==SLAVE_ADDR and [0]==0 (write).
  - The address byte is never stored in rx_data or counted in byte_count.
  - Mismatch or read bit → NACK, then WAIT_STOP.
- Undefined: every byte, including the first, is data; SLAVE_ADDR is ignored.

## Structure
- Package i2c_pkg:
  - rx_state_t enum (IDLE, RX_BIT, ACK, NACK, WAIT_STOP)
  - I2C_BYTE_W=8
  - I2C_BITS_PER_FRAME=9
  - bus_cond_t struct {start, stop, scl_rise, scl_fall}
- Sub-module i2c_bus_cond_detect: owns the SCL_d/SDA_d registers and outputs bus_cond_t.
- i2c_slave_rx_engine holds the FSM, shift register, rx_data file and counters.

## Test plan
- START, bytes 0xA5, 0x3C, STOP (macro off, NUM_BYTES=6) → ACK on both 9th clocks; rx_data[0]=0xA5, rx_data[1]=0x3C; byte_count=2; one done pulse.
- 7 bytes 0x01..0x07 with NUM_BYTES=6 → bytes 1–6 ACKed and stored; 7th NACKed (sda_oe=0); overflow=1; byte_count=6.
- Macro on, address 0x84 (0x42, write), then 0x55, STOP → ACK both; rx_data[0]=0x55; byte_count=1. Address 0x86 → NACK; later bytes ignored; no done pulse.
- START, 0x11, 4 bits of 0xF0, repeated START, 0x22, STOP → rx_data[0]=0x22; byte_count=1; exactly one done pulse.
- rst low during the 5th bit of byte 2 → sda_oe=0 and all outputs at reset values immediately. After release, the next full frame 0x99 is received correctly.
- enable dropped during the ACK phase → sda_oe=0 next cycle, busy=0, rx_data retained.
